seg7_scan_ctrl: RTL and testbench

//  Scan controller for the 4-digit common-anode 7-segment display on the BX board.
//  - Accepts a binary value over a valid/ready handshake.
//  - Converts it to BCD sequentially (double dabble, 1 bit/cycle).
//  - Commits the result only at a frame boundary, so no frame ever mixes old and new digits.
//  - Time-multiplexes the digits, with a blanking gap before each digit to suppress ghosting.

---
 rtl/seg7_scan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode 7-segment scan controller: handshake load, sequential
// binary-to-BCD conversion, frame-aligned commit and blanked digit multiplexing.
module seg7_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 4000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [13:0] VALUE,
  input  logic        VALUE_VLD,
  output logic        VALUE_RDY,
  input  logic [3:0]  DP,
  input  logic        LZ_BLANK,
  output logic [7:0]  SEG,
  output logic [3:0]  DIG,
  output logic        OVF
);
  localparam int unsigned BIN_W      = 14;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned ITER_W     = 4;
  localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [ITER_W-1:0] ITER_LAST  = ITER_W'(BIN_W - 1);

  typedef enum logic {PH_BLANK, PH_ON} phase_e;
  typedef enum logic [1:0] {LD_IDLE, LD_CONV, LD_WAIT} load_e;

  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  load_e              load_q, load_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [3:0]         pend_dp_q, pend_dp_d;
  logic               pend_lz_q, pend_lz_d;
  logic [15:0]        com_bcd_q, com_bcd_d;
  logic [3:0]         com_dp_q, com_dp_d;
  logic               com_lz_q, com_lz_d;
  logic               com_ovf_q, com_ovf_d;
  logic [3:0]         dig_q, dig_d;
  logic [7:0]         seg_q, seg_d;
  logic               rdy_q, rdy_d;
  logic               frame_start_c;
  logic [BCD_W+BIN_W-1:0] shifted_c;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int unsigned n = 0; n < BCD_DIGITS; n++) begin
      if (res[4*n +: 4] >= 4'd5) res[4*n +: 4] = res[4*n +: 4] + 4'd3;
    end
    return res;
  endfunction

  function automatic logic [7:0] seg_pattern(input logic [1:0] idx, input logic [15:0] bcd,
                                             input logic [3:0] dp, input logic lz, input logic ovf);
    logic [3:0] digit;
    logic       blank;
    logic [7:0] pat;
    case (idx)
      2'd0:    digit = bcd[15:12];
      2'd1:    digit = bcd[11:8];
      2'd2:    digit = bcd[7:4];
      default: digit = bcd[3:0];
    endcase
    blank = lz && (idx != 2'd3) && (bcd[15:12] == 4'd0)
         && ((idx == 2'd0) || (bcd[11:8] == 4'd0))
         && ((idx <= 2'd1) || (bcd[7:4] == 4'd0));
    case (digit)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = 8'hFF;
    endcase
    if (ovf)        pat = 8'hBF;
    else if (blank) pat = 8'hFF;
    if (dp[idx]) pat[7] = 1'b0;
    return pat;
  endfunction

  // Edge that leaves the last ON phase of digit 3 is the start of the next frame.
  assign frame_start_c = (phase_q == PH_ON) && (cnt_q == DIGIT_LAST) && (idx_q == 2'd3);
  assign shifted_c     = {bcd_adjust(bcd_q), bin_q} << 1;

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    load_d    = load_q;
    iter_d    = iter_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    pend_dp_d = pend_dp_q;
    pend_lz_d = pend_lz_q;
    com_bcd_d = com_bcd_q;
    com_dp_d  = com_dp_q;
    com_lz_d  = com_lz_q;
    com_ovf_d = com_ovf_q;

    if (phase_q == PH_ON) begin
      if (cnt_q == DIGIT_LAST) begin
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
        phase_d = (BLANK_CYCLES == 0) ? PH_ON : PH_BLANK;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if ((BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST)) begin
        cnt_d   = '0;
        phase_d = PH_ON;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (load_q)
      LD_IDLE: begin
        if (VALUE_VLD && rdy_q) begin
          bin_d     = VALUE;
          bcd_d     = '0;
          iter_d    = '0;
          pend_dp_d = DP;
          pend_lz_d = LZ_BLANK;
          load_d    = LD_CONV;
        end
      end
      LD_CONV: begin
        bcd_d  = shifted_c[BIN_W +: BCD_W];
        bin_d  = shifted_c[BIN_W-1:0];
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_LAST) load_d = LD_WAIT;
      end
      LD_WAIT: begin
        if (frame_start_c) begin
          com_bcd_d = bcd_q[15:0];
          com_dp_d  = pend_dp_q;
          com_lz_d  = pend_lz_q;
          com_ovf_d = |bcd_q[BCD_W-1:16];
          load_d    = LD_IDLE;
        end
      end
      default: load_d = LD_IDLE;
    endcase

    // Outputs follow the next state so a commit shows from the phase it coincides with.
    dig_d = (phase_d == PH_ON) ? (4'b0001 << idx_d) : 4'b0000;
    seg_d = (phase_d == PH_ON) ? seg_pattern(idx_d, com_bcd_d, com_dp_d, com_lz_d, com_ovf_d)
                               : 8'hFF;
    rdy_d = (load_d == LD_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q   <= PH_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      load_q    <= LD_IDLE;
      iter_q    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      pend_dp_q <= '0;
      pend_lz_q <= 1'b0;
      com_bcd_q <= '0;
      com_dp_q  <= '0;
      com_lz_q  <= 1'b0;
      com_ovf_q <= 1'b0;
      dig_q     <= 4'b0000;
      seg_q     <= 8'hFF;
      rdy_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      load_q    <= load_d;
      iter_q    <= iter_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      pend_dp_q <= pend_dp_d;
      pend_lz_q <= pend_lz_d;
      com_bcd_q <= com_bcd_d;
      com_dp_q  <= com_dp_d;
      com_lz_q  <= com_lz_d;
      com_ovf_q <= com_ovf_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
      rdy_q     <= rdy_d;
    end
  end

  assign VALUE_RDY = rdy_q;
  assign SEG       = seg_q;
  assign DIG       = dig_q;
  assign OVF       = com_ovf_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl against a decimal-arithmetic
// model of the scan timeline, handshake timing and committed display contents.
module tb_seg7_scan_ctrl;
  localparam int DIGIT_CYCLES = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int SLOT  = DIGIT_CYCLES + BLANK_CYCLES;
  localparam int FRAME = 4 * SLOT;
  localparam int CONV_CYCLES = 14;

  logic       CLK = 1'b0;
  logic       RST;
  logic [13:0] VALUE;
  logic       VALUE_VLD;
  logic       VALUE_RDY;
  logic [3:0] DP;
  logic       LZ_BLANK;
  logic [7:0] SEG;
  logic [3:0] DIG;
  logic       OVF;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int         m_val;
  logic [3:0] m_dp;
  logic       m_lz;
  logic [7:0] digit_pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         p10 [4] = '{1000, 100, 10, 1};

  seg7_scan_ctrl #(.DIGIT_CYCLES(DIGIT_CYCLES), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .VALUE_VLD(VALUE_VLD), .VALUE_RDY(VALUE_RDY),
    .DP(DP), .LZ_BLANK(LZ_BLANK), .SEG(SEG), .DIG(DIG), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Cycles since the last reset edge; the whole scan timeline is a function of this.
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  function automatic logic [3:0] exp_dig(input int t);
    int off, slot;
    off  = t % SLOT;
    slot = (t % FRAME) / SLOT;
    if (off < BLANK_CYCLES) return 4'b0000;
    return 4'(1 << slot);
  endfunction

  function automatic logic [7:0] exp_seg(input int t, input int v, input logic [3:0] dp, input logic lz);
    int off, slot;
    logic [7:0] p;
    off  = t % SLOT;
    slot = (t % FRAME) / SLOT;
    if (off < BLANK_CYCLES) return 8'hFF;
    if (v > 9999) p = 8'hBF;
    else if (lz && slot < 3 && v < p10[slot]) p = 8'hFF;
    else p = digit_pat[(v / p10[slot]) % 10];
    if (dp[slot]) p[7] = 1'b0;
    return p;
  endfunction

  // Accepted after cycle a: 14 conversion cycles, then wait for the next frame start.
  function automatic int next_commit(input int a);
    return ((a + CONV_CYCLES + 2 + FRAME - 1) / FRAME) * FRAME;
  endfunction

  task automatic test_reset();
    RST = 1'b1; VALUE_VLD = 1'b0; VALUE = '0; DP = '0; LZ_BLANK = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      total++;
      if (DIG !== 4'b0000 || SEG !== 8'hFF || VALUE_RDY !== 1'b0 || OVF !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: DIG=%b SEG=%h RDY=%b OVF=%b required 0000/ff/0/0", DIG, SEG, VALUE_RDY, OVF);
      end
    end
    RST = 1'b0;
    m_val = 0; m_dp = '0; m_lz = 1'b0;
    @(negedge CLK);
    total++;
    if (VALUE_RDY !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_rdy: RDY=%b required 1", VALUE_RDY);
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 2 * FRAME; i++) begin
      total++;
      if (DIG !== exp_dig(cyc) || SEG !== exp_seg(cyc, m_val, m_dp, m_lz) || OVF !== 1'b0) begin
        bad++;
        $display("FAIL scan cyc=%0d: DIG=%b SEG=%h OVF=%b required %b/%h/0", cyc, DIG, SEG, OVF,
                 exp_dig(cyc), exp_seg(cyc, m_val, m_dp, m_lz));
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_values();
    int         tv [6] = '{1234, 7, 0, 0, 12000, 9999};
    logic [3:0] td [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    logic       tl [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int v, a, c;
    logic [3:0] d;
    logic l, rdy_err;
    for (int n = 0; n < 14; n++) begin
      if (n < 6) begin
        v = tv[n]; d = td[n]; l = tl[n];
      end else begin
        v = (n % 2 == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 16383));
        d = 4'($urandom); l = 1'($urandom);
        repeat ($urandom_range(0, 30)) @(negedge CLK);
      end
      a = cyc; c = next_commit(a);
      VALUE = 14'(v); DP = d; LZ_BLANK = l; VALUE_VLD = 1'b1;
      @(negedge CLK);
      VALUE_VLD = 1'b0; VALUE = 14'($urandom); DP = 4'($urandom); LZ_BLANK = 1'($urandom);
      rdy_err = 1'b0;
      while (cyc < c) begin
        if (VALUE_RDY !== 1'b0) rdy_err = 1'b1;
        @(negedge CLK);
      end
      total++;
      if (rdy_err) begin
        bad++;
        $display("FAIL busy_window v=%0d: RDY went 1 before commit cycle %0d, required 0", v, c);
      end
      m_val = v; m_dp = d; m_lz = l;
      total++;
      if (VALUE_RDY !== 1'b1 || OVF !== (v > 9999)) begin
        bad++;
        $display("FAIL commit v=%0d: RDY=%b OVF=%b required 1/%b", v, VALUE_RDY, OVF, (v > 9999));
      end
      for (int t = 0; t < FRAME; t++) begin
        total++;
        if (DIG !== exp_dig(cyc) || SEG !== exp_seg(cyc, m_val, m_dp, m_lz)) begin
          bad++;
          $display("FAIL frame v=%0d dp=%b lz=%b cyc=%0d: DIG=%b SEG=%h required %b/%h", v, d, l, cyc,
                   DIG, SEG, exp_dig(cyc), exp_seg(cyc, m_val, m_dp, m_lz));
        end
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, c, c2, v0, v1;
    logic [3:0] d0, d1;
    logic l0, l1, exp_rdy;
    v0 = int'($urandom_range(0, 16383)); d0 = 4'($urandom); l0 = 1'($urandom);
    v1 = 0; d1 = '0; l1 = 1'b0;
    a = cyc; c = next_commit(a); c2 = next_commit(c);
    VALUE = 14'(v0); DP = d0; LZ_BLANK = l0; VALUE_VLD = 1'b1;
    @(negedge CLK);
    while (cyc < c2 + FRAME) begin
      if (cyc < c) begin
        VALUE = 14'($urandom); DP = 4'($urandom); LZ_BLANK = 1'($urandom);
      end else if (cyc == c) begin
        m_val = v0; m_dp = d0; m_lz = l0;
        v1 = int'($urandom_range(0, 16383)); d1 = 4'($urandom); l1 = 1'($urandom);
        VALUE = 14'(v1); DP = d1; LZ_BLANK = l1;
      end else begin
        VALUE_VLD = 1'b0;
      end
      if (cyc == c2) begin
        m_val = v1; m_dp = d1; m_lz = l1;
      end
      exp_rdy = (cyc == c) || (cyc >= c2);
      total++;
      if (VALUE_RDY !== exp_rdy || DIG !== exp_dig(cyc) || SEG !== exp_seg(cyc, m_val, m_dp, m_lz)) begin
        bad++;
        $display("FAIL back_to_back cyc=%0d: RDY=%b DIG=%b SEG=%h required %b/%b/%h", cyc, VALUE_RDY,
                 DIG, SEG, exp_rdy, exp_dig(cyc), exp_seg(cyc, m_val, m_dp, m_lz));
      end
      @(negedge CLK);
    end
    VALUE_VLD = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    VALUE = 14'd4321; DP = 4'b1111; LZ_BLANK = 1'b0; VALUE_VLD = 1'b1;
    @(negedge CLK);
    VALUE_VLD = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    m_val = 0; m_dp = '0; m_lz = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3 * FRAME; i++) begin
      total++;
      if (VALUE_RDY !== 1'b1 || OVF !== 1'b0 || DIG !== exp_dig(cyc) || SEG !== exp_seg(cyc, m_val, m_dp, m_lz)) begin
        bad++;
        $display("FAIL reset_mid_conv cyc=%0d: RDY=%b OVF=%b DIG=%b SEG=%h required 1/0/%b/%h", cyc,
                 VALUE_RDY, OVF, DIG, SEG, exp_dig(cyc), exp_seg(cyc, m_val, m_dp, m_lz));
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_values();
    test_back_to_back();
    test_back_to_back();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
